// File: rtl/control_unit_pipelined.sv
// ID/EX control-bundle register: RV32I/M decode, stall/flush handling and a
// multi-cycle sequencer for RV32M operations that holds IF/ID while it runs.
module control_unit_pipelined #(
   parameter bit          ENABLE_M    = 1'b1,
   parameter int unsigned MUL_LATENCY = 1,
   parameter int unsigned DIV_LATENCY = 32,
   parameter int unsigned CNT_WIDTH   = 6
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       IN_VALID,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNC3,
   input  logic [6:0] FUNC7,
   input  logic       STALL_IN,
   input  logic       FLUSH_IN,
   output logic       WRITE_EN,
   output logic       MEM_WRITE,
   output logic       MEM_READ,
   output logic       BRANCH,
   output logic       JUMP,
   output logic       PC_SELECT,
   output logic       IMM_SELECT,
   output logic       JAL_SELECT,
   output logic       DATA_MEM_SELECT,
   output logic [2:0] IMM_PICK,
   output logic [4:0] ALU_OP,
   output logic       OUT_VALID,
   output logic       ILLEGAL,
   output logic       MD_BUSY,
   output logic       MD_DONE,
   output logic       STALL_OUT
);

   localparam int unsigned IMM_W = 3;
   localparam int unsigned ALU_W = 5;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [IMM_W-1:0] IMM_I      = 3'b000;
   localparam logic [IMM_W-1:0] IMM_S      = 3'b001;
   localparam logic [IMM_W-1:0] IMM_B      = 3'b010;
   localparam logic [IMM_W-1:0] IMM_U      = 3'b011;
   localparam logic [IMM_W-1:0] IMM_J      = 3'b100;
   localparam logic [IMM_W-1:0] IMM_ISHAMT = 3'b101;

   typedef struct packed {
      logic             write_en;
      logic             mem_write;
      logic             mem_read;
      logic             branch;
      logic             jump;
      logic             pc_select;
      logic             imm_select;
      logic             jal_select;
      logic             data_mem_select;
      logic [IMM_W-1:0] imm_pick;
      logic [ALU_W-1:0] alu_op;
      logic             valid;
      logic             illegal;
   } ctrl_t;

   typedef enum logic {S_IDLE = 1'b0, S_MD_RUN = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   ctrl_t                bundle_q, bundle_d;

   ctrl_t                dec;
   logic                 dec_is_m;
   logic [31:0]          md_lat;
   logic                 md_start;
   logic [CNT_WIDTH-1:0] md_cnt_init;
   logic                 md_run;

   // Combinational decode of the incoming instruction fields.
   always_comb begin
      dec      = '0;
      dec.valid = 1'b1;
      dec_is_m = 1'b0;
      case (OPCODE)
         OP_OP: begin
            if (FUNC7 == F7_MULDIV) begin
               if (ENABLE_M) begin
                  dec.write_en = 1'b1;
                  dec.alu_op   = {1'b1, 1'b0, FUNC3};
                  dec_is_m     = 1'b1;
               end else begin
                  dec.illegal = 1'b1;
               end
            end else begin
               dec.write_en = 1'b1;
               dec.alu_op   = {1'b0, FUNC7[5], FUNC3};
            end
         end
         OP_IMM: begin
            dec.write_en   = 1'b1;
            dec.imm_select = 1'b1;
            dec.imm_pick   = (FUNC3[1:0] == 2'b01) ? IMM_ISHAMT : IMM_I;
            // FUNC7[5] is only an opcode bit for SRAI; elsewhere it is immediate
            dec.alu_op     = {1'b0, (FUNC3 == 3'b101) & FUNC7[5], FUNC3};
         end
         OP_LOAD: begin
            dec.write_en        = 1'b1;
            dec.mem_read        = 1'b1;
            dec.imm_select      = 1'b1;
            dec.data_mem_select = 1'b1;
            dec.imm_pick        = IMM_I;
         end
         OP_STORE: begin
            dec.mem_write  = 1'b1;
            dec.imm_select = 1'b1;
            dec.imm_pick   = IMM_S;
         end
         OP_BRANCH: begin
            dec.branch   = 1'b1;
            dec.imm_pick = IMM_B;
            dec.alu_op   = {2'b00, FUNC3};
         end
         OP_JAL: begin
            dec.write_en   = 1'b1;
            dec.jump       = 1'b1;
            dec.pc_select  = 1'b1;
            dec.imm_select = 1'b1;
            dec.jal_select = 1'b1;
            dec.imm_pick   = IMM_J;
         end
         OP_JALR: begin
            dec.write_en   = 1'b1;
            dec.jump       = 1'b1;
            dec.imm_select = 1'b1;
            dec.jal_select = 1'b1;
            dec.imm_pick   = IMM_I;
         end
         OP_LUI: begin
            dec.write_en   = 1'b1;
            dec.imm_select = 1'b1;
            dec.imm_pick   = IMM_U;
            dec.alu_op     = 5'b01111;
         end
         OP_AUIPC: begin
            dec.write_en   = 1'b1;
            dec.pc_select  = 1'b1;
            dec.imm_select = 1'b1;
            dec.imm_pick   = IMM_U;
         end
         OP_FENCE, OP_SYSTEM: begin
            dec.valid = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // EX latency of the decoded M-op and whether it needs the sequencer.
   always_comb begin
      md_lat      = FUNC3[2] ? 32'(DIV_LATENCY) : 32'(MUL_LATENCY);
      md_start    = dec_is_m & (md_lat > 32'd1);
      md_cnt_init = CNT_WIDTH'(md_lat - 32'd1);
   end

   // State, counter and bundle registers.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bundle_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bundle_q <= bundle_d;
      end
   end

   // Next state: flush beats the M-op hold, which beats stall, which beats load.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bundle_d = bundle_q;
      if (FLUSH_IN) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         bundle_d = '0;
      end else if (state_q == S_MD_RUN) begin
         if (cnt_q <= CNT_WIDTH'(1)) begin
            // upstream was held, so the next instruction loads one edge later
            state_d  = S_IDLE;
            cnt_d    = '0;
            bundle_d = '0;
         end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
         end
      end else if (!STALL_IN) begin
         if (IN_VALID) begin
            bundle_d = dec;
            if (md_start) begin
               state_d = S_MD_RUN;
               cnt_d   = md_cnt_init;
            end
         end else begin
            bundle_d = '0;
         end
      end
   end

   // Outputs come straight from the bundle register and sequencer state.
   assign md_run          = (state_q == S_MD_RUN);
   assign MD_BUSY         = md_run;
   assign MD_DONE         = md_run & (cnt_q == CNT_WIDTH'(1));
   assign STALL_OUT       = md_run;
   assign WRITE_EN        = bundle_q.write_en & (~md_run | MD_DONE);
   assign MEM_WRITE       = bundle_q.mem_write;
   assign MEM_READ        = bundle_q.mem_read;
   assign BRANCH          = bundle_q.branch;
   assign JUMP            = bundle_q.jump;
   assign PC_SELECT       = bundle_q.pc_select;
   assign IMM_SELECT      = bundle_q.imm_select;
   assign JAL_SELECT      = bundle_q.jal_select;
   assign DATA_MEM_SELECT = bundle_q.data_mem_select;
   assign IMM_PICK        = bundle_q.imm_pick;
   assign ALU_OP          = bundle_q.alu_op;
   assign OUT_VALID       = bundle_q.valid;
   assign ILLEGAL         = bundle_q.illegal;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Bench for control_unit_pipelined: directed scenarios plus randomized traffic
// checked against an instruction-class reference model (M enabled and disabled).
module tb_control_unit_pipelined;

   localparam int unsigned MUL_L = 2;
   localparam int unsigned DIV_L = 4;
   localparam int unsigned VW    = 22;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, stall_in, flush_in;
   logic [6:0] opcode, func7;
   logic [2:0] func3;

   logic       d_we, d_mw, d_mr, d_br, d_jump, d_pcs, d_imms, d_jals, d_dms;
   logic [2:0] d_imm;
   logic [4:0] d_alu;
   logic       d_ov, d_ill, d_busy, d_done, d_stall;
   logic       n_we, n_mw, n_mr, n_br, n_jump, n_pcs, n_imms, n_jals, n_dms;
   logic [2:0] n_imm;
   logic [4:0] n_alu;
   logic       n_ov, n_ill, n_busy, n_done, n_stall;

   wire [VW-1:0] obs0 = {d_we, d_mw, d_mr, d_br, d_jump, d_pcs, d_imms, d_jals, d_dms,
                         d_imm, d_alu, d_ov, d_ill, d_busy, d_done, d_stall};
   wire [VW-1:0] obs1 = {n_we, n_mw, n_mr, n_br, n_jump, n_pcs, n_imms, n_jals, n_dms,
                         n_imm, n_alu, n_ov, n_ill, n_busy, n_done, n_stall};

   control_unit_pipelined #(.ENABLE_M(1'b1), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L), .CNT_WIDTH(6)) dut (
      .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid), .OPCODE(opcode), .FUNC3(func3), .FUNC7(func7),
      .STALL_IN(stall_in), .FLUSH_IN(flush_in),
      .WRITE_EN(d_we), .MEM_WRITE(d_mw), .MEM_READ(d_mr), .BRANCH(d_br), .JUMP(d_jump),
      .PC_SELECT(d_pcs), .IMM_SELECT(d_imms), .JAL_SELECT(d_jals), .DATA_MEM_SELECT(d_dms),
      .IMM_PICK(d_imm), .ALU_OP(d_alu), .OUT_VALID(d_ov), .ILLEGAL(d_ill),
      .MD_BUSY(d_busy), .MD_DONE(d_done), .STALL_OUT(d_stall));

   control_unit_pipelined #(.ENABLE_M(1'b0), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L), .CNT_WIDTH(6)) dut_nm (
      .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid), .OPCODE(opcode), .FUNC3(func3), .FUNC7(func7),
      .STALL_IN(stall_in), .FLUSH_IN(flush_in),
      .WRITE_EN(n_we), .MEM_WRITE(n_mw), .MEM_READ(n_mr), .BRANCH(n_br), .JUMP(n_jump),
      .PC_SELECT(n_pcs), .IMM_SELECT(n_imms), .JAL_SELECT(n_jals), .DATA_MEM_SELECT(n_dms),
      .IMM_PICK(n_imm), .ALU_OP(n_alu), .OUT_VALID(n_ov), .ILLEGAL(n_ill),
      .MD_BUSY(n_busy), .MD_DONE(n_done), .STALL_OUT(n_stall));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: per-instance expected bundle {ctl9, imm3, alu5, valid, illegal}
   // and number of sequencer cycles still to be shown (0 when idle).
   typedef enum int {C_R, C_M, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
                     C_LUI, C_AUIPC, C_NOP, C_ILL} cls_t;

   logic [18:0] m_word [2];
   int          m_left [2];

   function automatic cls_t classify(input logic [6:0] op, input logic [6:0] f7, input bit en_m);
      cls_t c;
      case (op)
         7'b0110011: begin
            if (f7 != 7'b0000001) c = C_R;
            else if (en_m)        c = C_M;
            else                  c = C_ILL;
         end
         7'b0010011: c = C_IALU;
         7'b0000011: c = C_LOAD;
         7'b0100011: c = C_STORE;
         7'b1100011: c = C_BRANCH;
         7'b1101111: c = C_JAL;
         7'b1100111: c = C_JALR;
         7'b0110111: c = C_LUI;
         7'b0010111: c = C_AUIPC;
         7'b0001111: c = C_NOP;
         7'b1110011: c = C_NOP;
         default:    c = C_ILL;
      endcase
      return c;
   endfunction

   // ctl bit order: WE, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SEL, IMM_SEL, JAL_SEL, DMEM_SEL
   function automatic logic [18:0] ref_word(input cls_t c, input logic [2:0] f3, input logic [6:0] f7);
      logic [8:0] ctl;
      logic [2:0] imm;
      logic [4:0] alu;
      logic       ill;
      ctl = '0; imm = 3'b000; alu = '0; ill = 1'b0;
      case (c)
         C_R:      begin ctl = 9'b100000000; alu = {1'b0, f7[5], f3}; end
         C_M:      begin ctl = 9'b100000000; alu = {2'b10, f3}; end
         C_IALU:   begin
            ctl = 9'b100000100;
            imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
            alu = {1'b0, (f3 == 3'b101) ? f7[5] : 1'b0, f3};
         end
         C_LOAD:   ctl = 9'b101000101;
         C_STORE:  begin ctl = 9'b010000100; imm = 3'b001; end
         C_BRANCH: begin ctl = 9'b000100000; imm = 3'b010; alu = {2'b00, f3}; end
         C_JAL:    begin ctl = 9'b100011110; imm = 3'b100; end
         C_JALR:   ctl = 9'b100010110;
         C_LUI:    begin ctl = 9'b100000100; imm = 3'b011; alu = 5'b01111; end
         C_AUIPC:  begin ctl = 9'b100001100; imm = 3'b011; end
         C_ILL:    ill = 1'b1;
         default:  ill = 1'b0;
      endcase
      return {ctl, imm, alu, 1'b1, ill};
   endfunction

   function automatic logic [VW-1:0] exp_vec(input int k);
      logic        busy, done;
      logic [18:0] w;
      w    = m_word[k];
      busy = (m_left[k] > 0);
      done = (m_left[k] == 1);
      return {w[18] & (~busy | done), w[17:10], w[9:7], w[6:2], w[1], w[0], busy, done, busy};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_word[k] = '0;
         m_left[k] = 0;
      end
   endtask

   task automatic model_step();
      cls_t        c;
      int unsigned lat;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n || flush_in) begin
            m_word[k] = '0;
            m_left[k] = 0;
         end else if (m_left[k] > 0) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) m_word[k] = '0;
         end else if (stall_in) begin
            m_word[k] = m_word[k];
         end else if (in_valid) begin
            c         = classify(opcode, func7, (k == 0));
            m_word[k] = ref_word(c, func3, func7);
            lat       = func3[2] ? DIV_L : MUL_L;
            m_left[k] = (c == C_M && lat > 1) ? int'(lat) - 1 : 0;
         end else begin
            m_word[k] = '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      in_valid = v;
      opcode   = op;
      func3    = f3;
      func7    = f7;
   endtask

   task automatic clean();
      drive(1'b0, 7'd0, 3'd0, 7'd0);
      stall_in = 1'b0;
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stall_in = 1'b0;
      flush_in = 1'b0;
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
      model_reset();
      repeat (2) tick();
      total++; if (obs0 !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs0); end
      total++; if (obs1 !== '0) begin bad++; $display("FAIL reset_state_nm got=%h exp=0", obs1); end
      rst_n = 1'b1;
      drive(1'b0, 7'd0, 3'd0, 7'd0);
      tick();
   endtask

   task automatic test_add_sub();
      clean();
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
      tick();
      total++;
      if ({d_we, d_alu, d_ov, d_ill, d_stall} !== {1'b1, 5'b00000, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL add got we=%b alu=%b ov=%b exp we=1 alu=00000 ov=1", d_we, d_alu, d_ov);
      end
      drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
      tick();
      total++;
      if ({d_we, d_alu, d_ov} !== {1'b1, 5'b01000, 1'b1}) begin
         bad++; $display("FAIL sub got we=%b alu=%b exp we=1 alu=01000", d_we, d_alu);
      end
      drive(1'b0, 7'b0110011, 3'b000, 7'b0000000);
      tick();
      total++; if (obs0 !== '0) begin bad++; $display("FAIL bubble_after_sub got=%h exp=0", obs0); end
   endtask

   task automatic test_load_stall();
      clean();
      drive(1'b1, 7'b0000011, 3'b010, 7'b0000000);
      tick();
      drive(1'b1, 7'b0100011, 3'b010, 7'b0000000);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({d_mr, d_dms, d_imm, d_mw, d_we, d_ov} !== {1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL lw_hold cyc=%0d got mr=%b dms=%b imm=%b mw=%b exp mr=1 dms=1 imm=000 mw=0",
                            i, d_mr, d_dms, d_imm, d_mw);
         end
         if (i == 2) stall_in = 1'b0;
         tick();
      end
      total++;
      if ({d_mw, d_mr, d_imm} !== {1'b1, 1'b0, 3'b001}) begin
         bad++; $display("FAIL sw_after_stall got mw=%b mr=%b imm=%b exp mw=1 mr=0 imm=001", d_mw, d_mr, d_imm);
      end
   endtask

   task automatic test_div();
      clean();
      drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
      tick();
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
      for (int i = 1; i <= 3; i++) begin
         total++;
         if ({d_busy, d_stall, d_done, d_we, d_ov, d_alu} !==
             {1'b1, 1'b1, (i == 3), (i == 3), 1'b1, 5'b10100}) begin
            bad++; $display("FAIL div_run cyc=%0d got busy=%b stall=%b done=%b we=%b alu=%b exp done/we=%0d",
                            i, d_busy, d_stall, d_done, d_we, d_alu, (i == 3));
         end
         tick();
      end
      total++; if (obs0 !== '0) begin bad++; $display("FAIL div_bubble got=%h exp=0", obs0); end
      tick();
      total++;
      if ({d_we, d_alu, d_busy} !== {1'b1, 5'b00000, 1'b0}) begin
         bad++; $display("FAIL add_after_div got we=%b alu=%b busy=%b exp we=1 alu=00000 busy=0", d_we, d_alu, d_busy);
      end
      drive(1'b1, 7'b0110011, 3'b001, 7'b0000001);
      tick();
      total++;
      if ({d_busy, d_done, d_we, d_stall, d_alu} !== {1'b1, 1'b1, 1'b1, 1'b1, 5'b10001}) begin
         bad++; $display("FAIL mulh_single_run got busy=%b done=%b we=%b alu=%b exp 1 1 1 10001",
                         d_busy, d_done, d_we, d_alu);
      end
      drive(1'b0, 7'd0, 3'd0, 7'd0);
      tick();
      total++; if (obs0 !== '0) begin bad++; $display("FAIL mul_bubble got=%h exp=0", obs0); end
   endtask

   task automatic test_div_flush();
      logic saw_we, saw_done;
      saw_we = 1'b0;
      saw_done = 1'b0;
      clean();
      drive(1'b1, 7'b0110011, 3'b110, 7'b0000001);
      tick();
      drive(1'b0, 7'd0, 3'd0, 7'd0);
      saw_we |= d_we; saw_done |= d_done;
      tick();
      saw_we |= d_we; saw_done |= d_done;
      total++;
      if ({d_busy, d_stall, d_ov} !== 3'b111) begin
         bad++; $display("FAIL rem_run2 got busy=%b stall=%b ov=%b exp 111", d_busy, d_stall, d_ov);
      end
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      saw_we |= d_we; saw_done |= d_done;
      total++; if (obs0 !== '0) begin bad++; $display("FAIL flush_bubble got=%h exp=0", obs0); end
      tick();
      saw_we |= d_we; saw_done |= d_done;
      total++;
      if ({saw_we, saw_done} !== 2'b00) begin
         bad++; $display("FAIL flush_abort got we_seen=%b done_seen=%b exp 0 0", saw_we, saw_done);
      end
   endtask

   task automatic test_reset_mid_div();
      clean();
      drive(1'b1, 7'b0110011, 3'b101, 7'b0000001);
      tick();
      drive(1'b0, 7'd0, 3'd0, 7'd0);
      tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (obs0 !== '0) begin bad++; $display("FAIL reset_mid_div got=%h exp=0", obs0); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++;
      if ({d_busy, d_stall, d_ov} !== 3'b000) begin
         bad++; $display("FAIL after_reset_idle got busy=%b stall=%b ov=%b exp 000", d_busy, d_stall, d_ov);
      end
   endtask

   task automatic test_illegal();
      clean();
      drive(1'b1, 7'b1111111, 3'($urandom_range(7)), 7'($urandom_range(127)));
      tick();
      total++;
      if (obs0 !== {9'b0, 3'b000, 5'b00000, 1'b1, 1'b1, 3'b000}) begin
         bad++; $display("FAIL illegal_op got=%h exp=%h", obs0, {9'b0, 3'b000, 5'b00000, 1'b1, 1'b1, 3'b000});
      end
      drive(1'b1, 7'b0001111, 3'b000, 7'b0000000);
      tick();
      total++;
      if (obs0 !== {9'b0, 3'b000, 5'b00000, 1'b1, 1'b0, 3'b000}) begin
         bad++; $display("FAIL fence_nop got=%h exp=%h", obs0, {9'b0, 3'b000, 5'b00000, 1'b1, 1'b0, 3'b000});
      end
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
      tick();
      total++;
      if (obs1 !== {9'b0, 3'b000, 5'b00000, 1'b1, 1'b1, 3'b000}) begin
         bad++; $display("FAIL mul_without_m got=%h exp=%h", obs1, {9'b0, 3'b000, 5'b00000, 1'b1, 1'b1, 3'b000});
      end
      total++;
      if (obs0 !== {1'b1, 8'b0, 3'b000, 5'b10000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}) begin
         bad++; $display("FAIL mul_with_m got=%h exp=%h", obs0, {1'b1, 8'b0, 3'b000, 5'b10000, 1'b1, 1'b0, 3'b111});
      end
   endtask

   task automatic test_random();
      logic [6:0]   op_tab [0:12];
      logic [VW-1:0] got, exp;
      op_tab = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
      clean();
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid = ($urandom_range(99) < 85);
         stall_in = ($urandom_range(99) < 15);
         flush_in = ($urandom_range(99) < 5);
         opcode   = ($urandom_range(9) == 0) ? 7'($urandom_range(127)) : op_tab[$urandom_range(12)];
         func3    = 3'($urandom_range(7));
         case ($urandom_range(3))
            0:       func7 = 7'b0000000;
            1:       func7 = 7'b0100000;
            2:       func7 = 7'b0000001;
            default: func7 = 7'($urandom_range(127));
         endcase
         tick();
         for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? obs0 : obs1;
            exp = exp_vec(k);
            total++;
            if (got !== exp) begin
               bad++; $display("FAIL random inst=%0d cyc=%0d got=%h exp=%h", k, cyc, got, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_load_stall();
      test_div();
      test_div_flush();
      test_reset_mid_div();
      test_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
